// File: rtl/fmrv32im_axi_gpio_pw.sv
// fmrv32im_axi_gpio_pw: AXI4-Lite GPIO with direction, SET/CLR, byte strobes, input sync; edge IRQs under FMRV32IM_GPIO_IRQ_EN
module fmrv32im_axi_gpio_pw #(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [15:0]           S_AXI_AWADDR,
  input  logic [3:0]            S_AXI_AWCACHE,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  output logic [1:0]            S_AXI_BRESP,
  input  logic [15:0]           S_AXI_ARADDR,
  input  logic [3:0]            S_AXI_ARCACHE,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  input  logic [GPIO_WIDTH-1:0] GPIO_I,
  output logic [GPIO_WIDTH-1:0] GPIO_O,
  output logic [GPIO_WIDTH-1:0] GPIO_OE,
  output logic                  IRQ
);
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
  state_t state, state_n;
  logic [7:0] awaddr_q, waddr, wa, ra;
  logic we;
  logic [31:0] rdata_q, rd_val, m32;
  logic [GPIO_WIDTH-1:0] out_r, dir_r, m, wm, sync_in;
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;
  logic unused;
  assign unused = ^{S_AXI_AWADDR[15:8], S_AXI_ARADDR[15:8], S_AXI_AWCACHE, S_AXI_AWPROT,
                    S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_WDATA, m32};
  always_comb begin
    state_n = state;
    we = 1'b0;
    waddr = awaddr_q;
    case (state)
      IDLE:
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          state_n = WRESP;
          we = 1'b1;
          waddr = S_AXI_AWADDR[7:0];
        end else if (S_AXI_AWVALID) state_n = WDATA;
        else if (S_AXI_ARVALID) state_n = RDATA;
      WDATA:
        if (S_AXI_WVALID) begin
          state_n = WRESP;
          we = 1'b1;
        end
      WRESP: state_n = S_AXI_BREADY ? IDLE : WRESP;
      RDATA: state_n = S_AXI_RREADY ? IDLE : RDATA;
    endcase
  end
  assign S_AXI_AWREADY = state == IDLE;
  assign S_AXI_ARREADY = state == IDLE && !S_AXI_AWVALID;
  assign S_AXI_WREADY  = (state == IDLE && S_AXI_AWVALID) || state == WDATA;
  assign S_AXI_BVALID  = state == WRESP;
  assign S_AXI_RVALID  = state == RDATA;
  assign S_AXI_RDATA   = S_AXI_RVALID ? rdata_q : 32'd0;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign GPIO_O  = out_r;
  assign GPIO_OE = dir_r;
  assign wa  = waddr & 8'hFC;
  assign ra  = S_AXI_ARADDR[7:0] & 8'hFC;
  assign m32 = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
  assign m   = m32[GPIO_WIDTH-1:0];
  assign wm  = S_AXI_WDATA[GPIO_WIDTH-1:0] & m;
  assign sync_in = sync_q[SYNC_STAGES-1];
`ifdef FMRV32IM_GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] prev_in, rise_en, fall_en, stat, set_bits;
  assign set_bits = (sync_in & ~prev_in & rise_en) | (~sync_in & prev_in & fall_en);
  assign IRQ = |stat;
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      prev_in <= '0;
      rise_en <= '0;
      fall_en <= '0;
      stat    <= '0;
    end else begin
      prev_in <= sync_in;
      if (we && wa == 8'h14) rise_en <= (rise_en & ~m) | wm;
      if (we && wa == 8'h18) fall_en <= (fall_en & ~m) | wm;
      stat <= (stat & ~((we && wa == 8'h1C) ? wm : '0)) | set_bits;
    end
  assign rd_val = ra == 8'h00 ? 32'(out_r) : ra == 8'h04 ? 32'(sync_in) : ra == 8'h08 ? 32'(dir_r) :
                  ra == 8'h14 ? 32'(rise_en) : ra == 8'h18 ? 32'(fall_en) : ra == 8'h1C ? 32'(stat) : 32'd0;
`else
  assign IRQ = 1'b0;
  assign rd_val = ra == 8'h00 ? 32'(out_r) : ra == 8'h04 ? 32'(sync_in) : ra == 8'h08 ? 32'(dir_r) : 32'd0;
`endif
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state    <= IDLE;
      awaddr_q <= '0;
      rdata_q  <= '0;
      out_r    <= '0;
      dir_r    <= '0;
      sync_q   <= '0;
    end else begin
      state  <= state_n;
      sync_q <= {sync_q[SYNC_STAGES-2:0], GPIO_I};
      if (state == IDLE && S_AXI_AWVALID) awaddr_q <= S_AXI_AWADDR[7:0];
      if (state == IDLE && !S_AXI_AWVALID && S_AXI_ARVALID) rdata_q <= rd_val;
      if (we && wa == 8'h00) out_r <= (out_r & ~m) | wm;
      else if (we && wa == 8'h0C) out_r <= out_r | wm;
      else if (we && wa == 8'h10) out_r <= out_r & ~wm;
      if (we && wa == 8'h08) dir_r <= (dir_r & ~m) | wm;
    end
endmodule

// File: tb/tb_fmrv32im_axi_gpio_pw.sv
// tb_fmrv32im_axi_gpio_pw: directed bench; a 32-bit and an 8-bit instance share one bus and run in lockstep
module tb_fmrv32im_axi_gpio_pw;
  localparam int SS = 2;
  logic ACLK = 0, ARESETN = 0;
  always #5 ACLK = ~ACLK;
  logic [15:0] awaddr = 0, araddr = 0;
  logic [31:0] wdata = 0, gpio_i = 0;
  logic [3:0] wstrb = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, gpio_o, gpio_oe;
  logic awready8, wready8, bvalid8, arready8, rvalid8, irq8;
  logic [1:0] bresp8, rresp8;
  logic [31:0] rdata8;
  logic [7:0] gpio_o8, gpio_oe8;
  int checks = 0, errors = 0, lat = 0;
  logic [31:0] rd0, rd1;

  fmrv32im_axi_gpio_pw #(.GPIO_WIDTH(32), .SYNC_STAGES(SS)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARADDR(araddr), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .GPIO_I(gpio_i), .GPIO_O(gpio_o), .GPIO_OE(gpio_oe), .IRQ(irq));

  fmrv32im_axi_gpio_pw #(.GPIO_WIDTH(8), .SYNC_STAGES(SS)) dut8 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWCACHE(4'h0), .S_AXI_AWPROT(3'h0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready8),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready8),
    .S_AXI_BVALID(bvalid8), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp8),
    .S_AXI_ARADDR(araddr), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready8),
    .S_AXI_RDATA(rdata8), .S_AXI_RRESP(rresp8), .S_AXI_RVALID(rvalid8), .S_AXI_RREADY(rready),
    .GPIO_I(gpio_i[7:0]), .GPIO_O(gpio_o8), .GPIO_OE(gpio_oe8), .IRQ(irq8));

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // pre = idle cycles before raising the valids; the handshake lands pre+1 edges from now
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input int pre = 0);
    cyc(pre);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    cyc(1);
    awvalid = 0; wvalid = 0;
    lat = 1;
    while (!bvalid && lat < 10) begin cyc(1); lat++; end
    if (!bvalid) begin checks++; errors++; $display("FAIL wr_timeout addr=%h bvalid=%b required 1", a, bvalid); end
    bready = 1; cyc(1); bready = 0;
  endtask

  task automatic rd(input logic [15:0] a, input int pre = 0);
    cyc(pre);
    araddr = a; arvalid = 1;
    cyc(1);
    arvalid = 0;
    lat = 1;
    while (!rvalid && lat < 10) begin cyc(1); lat++; end
    if (!rvalid) begin checks++; errors++; $display("FAIL rd_timeout addr=%h rvalid=%b required 1", a, rvalid); end
    rd0 = rdata; rd1 = rdata8;
    rready = 1; cyc(1); rready = 0;
  endtask

  task automatic test_reset;
    cyc(2);
    ARESETN = 1;
    cyc(1);
    checks++; if ({awready, arready, wready, bvalid, rvalid, irq} !== 6'b110000) begin errors++; $display("FAIL reset_hs got %b exp 110000", {awready, arready, wready, bvalid, rvalid, irq}); end
    checks++; if ({rdata, gpio_o, gpio_oe, bresp, rresp} !== 100'd0) begin errors++; $display("FAIL reset_data rdata=%h o=%h oe=%h exp 0", rdata, gpio_o, gpio_oe); end
  endtask

  task automatic test_strobe;
    wr(16'h0000, 32'hA5A5_A5A5, 4'h3);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b_latency got %0d exp 1", lat); end
    rd(16'h0000);
    checks++; if (lat !== 1) begin errors++; $display("FAIL r_latency got %0d exp 1", lat); end
    checks++; if (rd0 !== 32'h0000_A5A5) begin errors++; $display("FAIL strb_out got %h exp 0000a5a5", rd0); end
    checks++; if (gpio_o !== 32'h0000_A5A5 || gpio_o8 !== 8'hA5) begin errors++; $display("FAIL strb_gpio got %h/%h exp 0000a5a5/a5", gpio_o, gpio_o8); end
  endtask

  task automatic test_set_clr;
    wr(16'h0000, 32'h0000_00F0, 4'hF);
    wr(16'h000C, 32'h0000_000F, 4'hF);
    wr(16'h0010, 32'h0000_0030, 4'hF);
    rd(16'h0000);
    checks++; if (rd0 !== 32'h0000_00CF) begin errors++; $display("FAIL set_clr got %h exp 000000cf", rd0); end
    rd(16'h000C);
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL set_read got %h exp 0", rd0); end
    wr(16'h000C, 32'hFFFF_FFFF, 4'b0100);
    wr(16'h0010, 32'hFFFF_FFFF, 4'b0000);
    rd(16'h0102);
    checks++; if (rd0 !== 32'h00FF_00CF) begin errors++; $display("FAIL set_strb_alias got %h exp 00ff00cf", rd0); end
    wr(16'h0008, 32'hFFFF_0000, 4'hF);
    checks++; if (gpio_oe !== 32'hFFFF_0000 || gpio_oe8 !== 8'h00) begin errors++; $display("FAIL dir got %h/%h exp ffff0000/00", gpio_oe, gpio_oe8); end
    wr(16'h0020, 32'hFFFF_FFFF, 4'hF);
    rd(16'h0020);
    checks++; if (rd0 !== 32'h0 || gpio_o !== 32'h00FF_00CF) begin errors++; $display("FAIL unmapped rd=%h o=%h exp 0/00ff00cf", rd0, gpio_o); end
  endtask

  task automatic test_width;
    wr(16'h0000, 32'hFFFF_FFFF, 4'hF);
    rd(16'h0000);
    checks++; if (rd0 !== 32'hFFFF_FFFF || rd1 !== 32'h0000_00FF) begin errors++; $display("FAIL width got %h/%h exp ffffffff/000000ff", rd0, rd1); end
  endtask

  task automatic test_sync;
    gpio_i = 32'h0000_005A;
    rd(16'h0004, SS - 1);
    checks++; if (rd0 !== 32'h0 || rd1 !== 32'h0) begin errors++; $display("FAIL sync_early got %h/%h exp 0/0", rd0, rd1); end
    gpio_i = 32'h8000_003C;
    rd(16'h0004, SS);
    checks++; if (rd0 !== 32'h8000_003C || rd1 !== 32'h0000_003C) begin errors++; $display("FAIL sync_on_time got %h/%h exp 8000003c/0000003c", rd0, rd1); end
  endtask

`ifdef FMRV32IM_GPIO_IRQ_EN
  task automatic test_irq;
    gpio_i = 32'h2;
    cyc(5);
    wr(16'h0014, 32'h1, 4'hF);
    wr(16'h0018, 32'h2, 4'hF);
    gpio_i = 32'h1;
    cyc(5);
    rd(16'h001C);
    checks++; if (rd0 !== 32'h3 || irq !== 1'b1) begin errors++; $display("FAIL irq_set stat=%h irq=%b exp 3/1", rd0, irq); end
    wr(16'h001C, 32'h1, 4'hF);
    rd(16'h001C);
    checks++; if (rd0 !== 32'h2 || irq !== 1'b1) begin errors++; $display("FAIL w1c_bit0 stat=%h irq=%b exp 2/1", rd0, irq); end
    wr(16'h001C, 32'h2, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_bit1 irq=%b exp 0", irq); end
    gpio_i = 32'h0;
    cyc(5);
    gpio_i = 32'h1;
    wr(16'h001C, 32'h1, 4'hF, SS);
    rd(16'h001C);
    checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL set_beats_w1c stat=%h exp 1", rd0); end
    wr(16'h001C, 32'hFFFF_FFFF, 4'h0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_strb0 irq=%b exp 1", irq); end
    wr(16'h001C, 32'hFFFF_FFFF, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_all irq=%b exp 0", irq); end
  endtask
`else
  task automatic test_irq;
    wr(16'h0014, 32'hFFFF_FFFF, 4'hF);
    wr(16'h0018, 32'hFFFF_FFFF, 4'hF);
    gpio_i = 32'h0;
    cyc(5);
    gpio_i = 32'hF;
    cyc(5);
    rd(16'h0014);
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL no_irq_rise_en got %h exp 0", rd0); end
    rd(16'h001C);
    checks++; if (rd0 !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL no_irq_stat stat=%h irq=%b exp 0/0", rd0, irq); end
  endtask
`endif

  task automatic test_priority;
    bit ok = 1;
    awaddr = 16'h0000; wdata = 32'h1111_2222; wstrb = 4'hF; araddr = 16'h0000;
    awvalid = 1; wvalid = 1; arvalid = 1;
    cyc(1);
    awvalid = 0; wvalid = 0;
    checks++; if ({bvalid, rvalid, arready} !== 3'b100) begin errors++; $display("FAIL prio_write_first got %b exp 100", {bvalid, rvalid, arready}); end
    for (int i = 0; i < 5; i++) begin cyc(1); ok &= bvalid & !rvalid & !arready; end
    checks++; if (!ok) begin errors++; $display("FAIL bvalid_hold bvalid=%b rvalid=%b exp 1/0", bvalid, rvalid); end
    checks++; if (gpio_o !== 32'h1111_2222) begin errors++; $display("FAIL prio_gpio got %h exp 11112222", gpio_o); end
    bready = 1; cyc(1); bready = 0;
    checks++; if ({arready, rvalid, bvalid} !== 3'b100) begin errors++; $display("FAIL prio_idle got %b exp 100", {arready, rvalid, bvalid}); end
    cyc(1);
    arvalid = 0;
    cyc(2);
    checks++; if (rvalid !== 1'b1 || rdata !== 32'h1111_2222) begin errors++; $display("FAIL prio_read rvalid=%b rdata=%h exp 1/11112222", rvalid, rdata); end
    rready = 1; cyc(1); rready = 0;
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL rdata_idle rvalid=%b rdata=%h exp 0/0", rvalid, rdata); end
  endtask

  task automatic test_aw_first;
    awaddr = 16'h0000; awvalid = 1;
    cyc(1);
    awvalid = 0; awaddr = 16'h0008;
    cyc(3);
    checks++; if ({wready, bvalid, awready} !== 3'b100) begin errors++; $display("FAIL wdata_state got %b exp 100", {wready, bvalid, awready}); end
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
    cyc(1);
    wvalid = 0;
    checks++; if (bvalid !== 1'b1 || gpio_o !== 32'h0BAD_F00D || gpio_oe !== 32'hFFFF_0000) begin errors++; $display("FAIL aw_first bvalid=%b o=%h oe=%h exp 1/0badf00d/ffff0000", bvalid, gpio_o, gpio_oe); end
    bready = 1; cyc(1); bready = 0;
  endtask

  task automatic test_reset_mid;
    araddr = 16'h0000; arvalid = 1;
    cyc(1);
    arvalid = 0;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_rvalid got %b exp 1", rvalid); end
    ARESETN = 0;
    #2;
    checks++; if ({rvalid, arready} !== 2'b01 || gpio_o !== 32'h0 || gpio_oe !== 32'h0) begin errors++; $display("FAIL reset_mid rv/arr=%b o=%h oe=%h exp 01/0/0", {rvalid, arready}, gpio_o, gpio_oe); end
    cyc(1);
    ARESETN = 1;
    cyc(1);
    rd(16'h0000);
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL post_reset_out got %h exp 0", rd0); end
  endtask

  initial begin
    test_reset;
    test_strobe;
    test_set_clr;
    test_width;
    test_sync;
    test_irq;
    test_priority;
    test_aw_first;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
